cache_cmu: RTL and testbench

- Cache management unit that sits directly upstream of the 2-way set-associative cache storage array.
- Accepts CPU load/store requests and drives the array's load/store/replace/invalid strobes.
- On a miss it runs a write-back of the dirty LRU victim, then a line fill from main memory.
- Policy: write-back, write-allocate; stalls the CPU until the request hits.

---
 rtl/cache_cmu_pkg.sv | 27 ++
 rtl/cmu_line_seq.sv | 31 +++
 rtl/cache_cmu.sv | 209 ++++++++++++++++++++
 tb/tb_cache_cmu.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_cmu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_cmu_pkg
//  Brief    : Address field widths, FSM state encoding and width codes shared
//             by the cache management unit.
//  Revision : 1.0  initial release
// ============================================================================
package cache_cmu_pkg;

    localparam int C_ADDR_BITS        = 32;
    localparam int C_TAG_BITS         = 23;
    localparam int C_SET_INDEX_WIDTH  = 5;
    localparam int C_LINE_WORDS       = 4;
    localparam int C_LINE_WORDS_WIDTH = 2;
    localparam int C_BYTE_OFF_BITS    = 2;

    localparam logic [2:0] C_WIDTH_WORD = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BACK = 2'd1,
        S_FILL = 2'd2,
        S_WAIT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cmu_line_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cmu_line_seq
//  Brief    : Word counter with last-word detect for line write-back and fill.
//  Revision : 1.0  initial release
// ============================================================================
module cmu_line_seq #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_WIDTH  = 2
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            // Wraps to zero on the final word, which coincides with the state change
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign last = (cnt == CNT_WIDTH'(LINE_WORDS - 1));

endmodule
`default_nettype wire

// File: rtl/cache_cmu.sv
`default_nettype none
// ============================================================================
//  Module   : cache_cmu
//  Brief    : Write-back / write-allocate controller for a 2-way cache array.
//             Optional hit/miss statistics counters under macro CMU_STAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module cache_cmu
    import cache_cmu_pkg::*;
#(
    parameter int ADDR_BITS        = C_ADDR_BITS,
    parameter int TAG_BITS         = C_TAG_BITS,
    parameter int SET_INDEX_WIDTH  = C_SET_INDEX_WIDTH,
    parameter int LINE_WORDS       = C_LINE_WORDS,
    parameter int LINE_WORDS_WIDTH = C_LINE_WORDS_WIDTH
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr_rw,
    input  logic                 en_r,
    input  logic                 en_w,
    input  logic [2:0]           u_b_h_w,
    input  logic [31:0]          data_w,
    output logic [31:0]          data_r,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_store,
    output logic                 cache_replace,
    output logic                 cache_invalid,
    output logic [2:0]           cache_u_b_h_w,
    output logic [31:0]          cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [31:0]          cache_dout,
    output logic                 mem_cs_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [31:0]          mem_data_o,
    input  logic [31:0]          mem_data_i,
    input  logic                 mem_ack_i
`ifdef CMU_STAT_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);

    localparam int TAG_LSB = ADDR_BITS - TAG_BITS;
    localparam int IDX_LSB = TAG_LSB - SET_INDEX_WIDTH;
    localparam logic [C_BYTE_OFF_BITS-1:0] C_BYTE_ZERO = '0;

    state_t                      r_state, w_next;
    logic [TAG_BITS-1:0]         r_req_tag, r_victim_tag;
    logic [SET_INDEX_WIDTH-1:0]  r_req_idx;
    logic [LINE_WORDS_WIDTH-1:0] w_cnt;
    logic                        w_last, w_cnt_clr, w_cnt_inc, w_latch, w_req;
    logic [ADDR_BITS-1:0]        w_fill_addr, w_back_addr;

    assign w_req         = en_r | en_w;
    assign w_fill_addr   = {r_req_tag,    r_req_idx, w_cnt, C_BYTE_ZERO};
    assign w_back_addr   = {r_victim_tag, r_req_idx, w_cnt, C_BYTE_ZERO};
    assign cache_invalid = 1'b0;

    cmu_line_seq #(
        .LINE_WORDS (LINE_WORDS),
        .CNT_WIDTH  (LINE_WORDS_WIDTH)
    ) u_line_seq (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_cnt_clr),
        .inc  (w_cnt_inc),
        .cnt  (w_cnt),
        .last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_tag    <= '0;
            r_req_idx    <= '0;
            r_victim_tag <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_req_tag    <= addr_rw[ADDR_BITS-1:TAG_LSB];
                r_req_idx    <= addr_rw[TAG_LSB-1:IDX_LSB];
                r_victim_tag <= cache_tag;
            end
        end
    end

    // Array address kept apart from the status-dependent logic: hit/dout are
    // functions of cache_addr, so this block must not read them.
    always_comb begin
        cache_addr    = '0;
        cache_u_b_h_w = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    cache_addr    = addr_rw;
                    cache_u_b_h_w = u_b_h_w;
                end
            end
            S_BACK, S_FILL: begin
                cache_addr    = w_fill_addr;
                cache_u_b_h_w = C_WIDTH_WORD;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_latch       = 1'b0;
        stall         = 1'b0;
        data_r        = '0;
        cache_load    = 1'b0;
        cache_store   = 1'b0;
        cache_replace = 1'b0;
        cache_din     = '0;
        mem_cs_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (cache_hit) begin
                        if (en_w) begin
                            cache_store = 1'b1;
                            cache_din   = data_w;
                        end else begin
                            cache_load = 1'b1;
                            data_r     = cache_dout;
                        end
                    end else begin
                        stall     = 1'b1;
                        w_latch   = 1'b1;
                        w_cnt_clr = 1'b1;
                        w_next    = (cache_valid && cache_dirty) ? S_BACK : S_FILL;
                    end
                end
            end
            S_BACK: begin
                // Array still misses on the request tag, so dout is the victim word
                stall      = 1'b1;
                mem_cs_o   = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = w_back_addr;
                mem_data_o = cache_dout;
                if (mem_ack_i) begin
                    w_cnt_inc = 1'b1;
                    if (w_last) begin
                        w_next = S_FILL;
                    end
                end
            end
            S_FILL: begin
                stall      = 1'b1;
                mem_cs_o   = 1'b1;
                mem_addr_o = w_fill_addr;
                if (mem_ack_i) begin
                    cache_replace = 1'b1;
                    cache_din     = mem_data_i;
                    w_cnt_inc     = 1'b1;
                    if (w_last) begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef CMU_STAT_EN
    logic r_retry;
    logic w_hit_done;

    // The first idle cycle after a refill is the retry of the missed request
    assign w_hit_done = (r_state == S_IDLE) && w_req && cache_hit && !r_retry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retry  <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            r_retry <= (r_state == S_WAIT);
            if (w_hit_done && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (w_latch && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_cmu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_cmu
//  Brief    : Directed bench for cache_cmu with a behavioural array and memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_cmu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_rw;
    logic        en_r, en_w;
    logic [2:0]  u_b_h_w;
    logic [31:0] data_w, data_r;
    logic        stall;
    logic [31:0] cache_addr;
    logic        cache_load, cache_store, cache_replace, cache_invalid;
    logic [2:0]  cache_u_b_h_w;
    logic [31:0] cache_din;
    logic        cache_hit, cache_valid, cache_dirty;
    logic [22:0] cache_tag;
    logic [31:0] cache_dout;
    logic        mem_cs_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic        mem_ack_i;
`ifdef CMU_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    cache_cmu dut (
        .clk(clk), .rst(rst), .addr_rw(addr_rw), .en_r(en_r), .en_w(en_w),
        .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(data_r), .stall(stall),
        .cache_addr(cache_addr), .cache_load(cache_load), .cache_store(cache_store),
        .cache_replace(cache_replace), .cache_invalid(cache_invalid),
        .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din),
        .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
        .cache_tag(cache_tag), .cache_dout(cache_dout),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef CMU_STAT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural cache array: one line per set is enough for these scenarios
    logic [22:0] m_tag   [32];
    logic        m_valid [32];
    logic        m_dirty [32];
    logic [31:0] m_data  [32][4];
    logic [4:0]  ca_idx;
    logic [1:0]  ca_w;
    logic        m_clr = 1'b0;
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx;
    logic [22:0] pl_tag;
    logic        pl_dirty;
    logic [31:0] pl_base;
    int          n_replace = 0;

    assign ca_idx      = cache_addr[8:4];
    assign ca_w        = cache_addr[3:2];
    assign cache_hit   = m_valid[ca_idx] && (m_tag[ca_idx] == cache_addr[31:9]);
    assign cache_valid = m_valid[ca_idx];
    assign cache_dirty = m_dirty[ca_idx];
    assign cache_tag   = m_tag[ca_idx];
    assign cache_dout  = m_data[ca_idx][ca_w];

    // Memory: word at address A reads back as {16'hD000, A[15:0]}
    int lat = 1;
    int wcnt = 0;
    assign mem_data_i = {16'hD000, mem_addr_o[15:0]};

    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        if (!mem_cs_o) begin
            mem_ack_i <= 1'b0;
            wcnt      <= 0;
        end else if (wcnt >= lat - 1) begin
            mem_ack_i <= 1'b1;
            wcnt      <= 0;
        end else begin
            mem_ack_i <= 1'b0;
            wcnt      <= wcnt + 1;
        end
    end

    always @(posedge clk) begin
        if (m_clr) begin
            for (int i = 0; i < 32; i++) begin
                m_valid[i] <= 1'b0;
                m_dirty[i] <= 1'b0;
                m_tag[i]   <= '0;
            end
        end else if (pl_en) begin
            m_valid[pl_idx] <= 1'b1;
            m_tag[pl_idx]   <= pl_tag;
            m_dirty[pl_idx] <= pl_dirty;
            for (int w = 0; w < 4; w++) m_data[pl_idx][w] <= pl_base + 32'(w);
        end else begin
            if (cache_replace) begin
                m_data[ca_idx][ca_w] <= cache_din;
                m_tag[ca_idx]        <= cache_addr[31:9];
                m_valid[ca_idx]      <= 1'b1;
                m_dirty[ca_idx]      <= 1'b0;
                n_replace            <= n_replace + 1;
            end
            if (cache_store) begin
                m_data[ca_idx][ca_w] <= cache_din;
                m_dirty[ca_idx]      <= 1'b1;
            end
            if (mem_cs_o && mem_ack_i) begin
                log_addr.push_back(mem_addr_o);
                log_we.push_back(mem_we_o);
                log_data.push_back(mem_we_o ? mem_data_o : mem_data_i);
            end
        end
    end

    task automatic preload(input logic [4:0] idx, input logic [22:0] tag,
                           input logic dirty, input logic [31:0] base);
        @(negedge clk);
        pl_idx = idx; pl_tag = tag; pl_dirty = dirty; pl_base = base; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Drives a request and holds it until stall drops; returns stalled cycles
    task automatic do_request(input logic [31:0] a, input logic r, input logic w,
                              input logic [2:0] f, input logic [31:0] d,
                              output int n_stall, output bit tmo);
        @(negedge clk);
        addr_rw = a; en_r = r; en_w = w; u_b_h_w = f; data_w = d;
        #1;
        n_stall = 0;
        while (stall && n_stall < 200) begin
            n_stall++;
            @(negedge clk);
            #1;
        end
        tmo = stall;
    endtask

    task automatic idle_req();
        @(negedge clk);
        en_r = 1'b0; en_w = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_clr = 1'b1;
        addr_rw = '0; en_r = 1'b0; en_w = 1'b0; u_b_h_w = '0; data_w = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        m_clr = 1'b0; rst = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (mem_cs_o !== 1'b0) begin errors++; $display("FAIL reset_mem_cs: got %b want 0", mem_cs_o); end
        checks++; if ({cache_load, cache_store, cache_replace, cache_invalid} !== 4'b0)
            begin errors++; $display("FAIL reset_strobes: got %b want 0000", {cache_load, cache_store, cache_replace, cache_invalid}); end
        checks++; if (data_r !== 32'h0) begin errors++; $display("FAIL reset_data_r: got %h want 0", data_r); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr_o); end
    endtask

    task automatic test_read_hit();
        int n; bit tmo;
        preload(5'd16, 23'h0, 1'b0, 32'hCAFE_0000);
        do_request(32'h0000_0104, 1'b1, 1'b0, 3'b010, 32'h0, n, tmo);
        checks++; if (n !== 0) begin errors++; $display("FAIL hit_stall_cycles: got %0d want 0", n); end
        checks++; if (cache_load !== 1'b1) begin errors++; $display("FAIL hit_load: got %b want 1", cache_load); end
        checks++; if (data_r !== 32'hCAFE_0001) begin errors++; $display("FAIL hit_data_r: got %h want cafe0001", data_r); end
        checks++; if (cache_addr !== 32'h0000_0104) begin errors++; $display("FAIL hit_cache_addr: got %h want 00000104", cache_addr); end
        checks++; if (cache_u_b_h_w !== 3'b010) begin errors++; $display("FAIL hit_width: got %b want 010", cache_u_b_h_w); end
        idle_req();
    endtask

    task automatic test_clean_miss();
        int n; bit tmo; int base; int rep0;
        lat = 2;
        base = log_addr.size(); rep0 = n_replace;
        do_request(32'h0000_0200, 1'b1, 1'b0, 3'b010, 32'h0, n, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL clean_timeout: stall still %b", stall); end
        checks++; if (n !== 10) begin errors++; $display("FAIL clean_stall_cycles: got %0d want 10", n); end
        checks++; if (cache_load !== 1'b1 || data_r !== 32'hD000_0200)
            begin errors++; $display("FAIL clean_retry: load %b data %h want 1 d0000200", cache_load, data_r); end
        checks++; if (n_replace - rep0 !== 4) begin errors++; $display("FAIL clean_replaces: got %0d want 4", n_replace - rep0); end
        checks++;
        if (log_addr.size() - base !== 4) begin
            errors++; $display("FAIL clean_mem_count: got %0d want 4", log_addr.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (log_addr[base+i] !== 32'h200 + 32'(4*i) || log_we[base+i] !== 1'b0) begin
                    errors++;
                    $display("FAIL clean_mem_%0d: addr %h we %b want %h 0", i, log_addr[base+i], log_we[base+i], 32'h200 + 32'(4*i));
                end
            end
        end
        idle_req();
    endtask

    task automatic test_dirty_miss();
        int n; bit tmo; int base;
        lat = 1;
        preload(5'd0, 23'h1, 1'b1, 32'h5A5A_0000);
        base = log_addr.size();
        do_request(32'h0000_0400, 1'b1, 1'b0, 3'b010, 32'h0, n, tmo);
        checks++; if (tmo || n !== 10) begin errors++; $display("FAIL dirty_stall_cycles: got %0d tmo %b want 10", n, tmo); end
        checks++; if (data_r !== 32'hD000_0400) begin errors++; $display("FAIL dirty_retry_data: got %h want d0000400", data_r); end
        checks++;
        if (log_addr.size() - base !== 8) begin
            errors++; $display("FAIL dirty_mem_count: got %0d want 8", log_addr.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (log_addr[base+i] !== 32'h200 + 32'(4*i) || log_we[base+i] !== 1'b1 ||
                    log_data[base+i] !== 32'h5A5A_0000 + 32'(i)) begin
                    errors++;
                    $display("FAIL dirty_wb_%0d: addr %h we %b data %h want %h 1 %h", i, log_addr[base+i],
                             log_we[base+i], log_data[base+i], 32'h200 + 32'(4*i), 32'h5A5A_0000 + 32'(i));
                end
                if (log_addr[base+4+i] !== 32'h400 + 32'(4*i) || log_we[base+4+i] !== 1'b0) begin
                    errors++;
                    $display("FAIL dirty_fill_%0d: addr %h we %b want %h 0", i, log_addr[base+4+i], log_we[base+4+i], 32'h400 + 32'(4*i));
                end
            end
        end
        idle_req();
    endtask

    task automatic test_write_miss();
        int n; bit tmo;
        lat = 1;
        do_request(32'h0000_0601, 1'b0, 1'b1, 3'b000, 32'h0000_00AB, n, tmo);
        checks++; if (tmo || n !== 6) begin errors++; $display("FAIL wmiss_stall_cycles: got %0d tmo %b want 6", n, tmo); end
        checks++; if (cache_store !== 1'b1 || cache_load !== 1'b0)
            begin errors++; $display("FAIL wmiss_store: store %b load %b want 1 0", cache_store, cache_load); end
        checks++; if (cache_din !== 32'h0000_00AB) begin errors++; $display("FAIL wmiss_din: got %h want 000000ab", cache_din); end
        checks++; if (cache_u_b_h_w !== 3'b000 || cache_addr !== 32'h0000_0601)
            begin errors++; $display("FAIL wmiss_addr_width: %h %b want 00000601 000", cache_addr, cache_u_b_h_w); end
        idle_req();
    endtask

    task automatic test_reset_mid_fill();
        int base; int reads; int k;
        lat = 1;
        base = log_addr.size(); reads = 0; k = 0;
        @(negedge clk);
        addr_rw = 32'h0000_0800; en_r = 1'b1; en_w = 1'b0; u_b_h_w = 3'b010;
        while (reads < 2 && k < 200) begin
            @(negedge clk);
            k++;
            reads = 0;
            for (int i = base; i < log_addr.size(); i++) if (log_we[i] === 1'b0) reads++;
        end
        checks++; if (reads !== 2) begin errors++; $display("FAIL rstfill_acks: got %0d reads want 2", reads); end
        rst = 1'b1; en_r = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (mem_cs_o !== 1'b0) begin errors++; $display("FAIL rstfill_mem_cs: got %b want 0", mem_cs_o); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstfill_stall: got %b want 0", stall); end
        checks++; if (cache_invalid !== 1'b0 || cache_replace !== 1'b0)
            begin errors++; $display("FAIL rstfill_strobes: inv %b rep %b want 0 0", cache_invalid, cache_replace); end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n; bit tmo;
        preload(5'd5, 23'h7, 1'b0, 32'hB0B0_0000);
        do_request(32'h0000_0E50, 1'b1, 1'b0, 3'b010, 32'h0, n, tmo);
        checks++; if (n !== 0 || data_r !== 32'hB0B0_0000) begin errors++; $display("FAIL b2b_hit0: stall %0d data %h want 0 b0b00000", n, data_r); end
        do_request(32'h0000_0E58, 1'b1, 1'b0, 3'b010, 32'h0, n, tmo);
        checks++; if (n !== 0 || data_r !== 32'hB0B0_0002) begin errors++; $display("FAIL b2b_hit2: stall %0d data %h want 0 b0b00002", n, data_r); end
        do_request(32'h0000_0E54, 1'b1, 1'b1, 3'b010, 32'h0000_1234, n, tmo);
        checks++; if (n !== 0 || cache_store !== 1'b1 || cache_load !== 1'b0)
            begin errors++; $display("FAIL b2b_rw_prio: stall %0d store %b load %b want 0 1 0", n, cache_store, cache_load); end
        checks++; if (cache_din !== 32'h0000_1234 || data_r !== 32'h0)
            begin errors++; $display("FAIL b2b_rw_data: din %h data_r %h want 00001234 0", cache_din, data_r); end
        idle_req();
    endtask

`ifdef CMU_STAT_EN
    task automatic test_stats();
        int n; bit tmo;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0)
            begin errors++; $display("FAIL stat_reset: hit %0d miss %0d want 0 0", hit_cnt, miss_cnt); end
        do_request(32'h0000_0E50, 1'b1, 1'b0, 3'b010, 32'h0, n, tmo);
        do_request(32'h0000_0E54, 1'b1, 1'b0, 3'b010, 32'h0, n, tmo);
        do_request(32'h0000_0E58, 1'b1, 1'b0, 3'b010, 32'h0, n, tmo);
        idle_req();
        do_request(32'h0000_0060, 1'b1, 1'b0, 3'b010, 32'h0, n, tmo);
        idle_req();
        do_request(32'h0000_0260, 1'b1, 1'b0, 3'b010, 32'h0, n, tmo);
        idle_req();
        #1;
        checks++; if (hit_cnt !== 32'd3) begin errors++; $display("FAIL stat_hits: got %0d want 3", hit_cnt); end
        checks++; if (miss_cnt !== 32'd2) begin errors++; $display("FAIL stat_misses: got %0d want 2", miss_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_dirty_miss();
        test_write_miss();
        test_reset_mid_fill();
        test_back_to_back();
`ifdef CMU_STAT_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
